// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue stage in front of the ALU593 top.
// Define ALU_SEQ_STATS_EN to add the stat_cmds/stat_errs handshake counters.
package tinyalu_pkg;
  typedef enum logic [2:0] {
    op_nop  = 3'b000,
    op_add  = 3'b001,
    op_and  = 3'b010,
    op_xor  = 3'b011,
    op_mul  = 3'b100,
    op_nop1 = 3'b101,
    op_res1 = 3'b110,
    op_res2 = 3'b111
  } alu_opcode_t;
endpackage

module alu_cmd_sequencer
  import tinyalu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  input  alu_opcode_t            cmd_op,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output alu_opcode_t            alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result,
  input  logic                   alu_error,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_result,
  output logic                   rsp_error,
  output logic                   rsp_timeout,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]            stat_cmds,
  output logic [15:0]            stat_errs
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    alu_opcode_t      op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [7:0]       aluA_q, aluA_d, aluB_q, aluB_d;
  alu_opcode_t      aluOp_q, aluOp_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       timer_q, timer_d;
  logic [15:0]      result_q, result_d;
  logic             error_q, error_d, timeout_q, timeout_d;
  logic             push, pop;
  cmd_t             head;

  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluOp_d   = aluOp_q;
    tag_d     = tag_q;
    timer_d   = timer_q;
    result_d  = result_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          tag_d = head.tag;
          // NOPs are answered locally and never reach the ALU
          if (head.op inside {op_nop, op_nop1}) begin
            result_d  = 16'h0000;
            error_d   = 1'b0;
            timeout_d = 1'b0;
            state_d   = RESP;
          end else begin
            aluA_d  = head.a;
            aluB_d  = head.b;
            aluOp_d = head.op;
            timer_d = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (alu_done) begin
          result_d  = alu_result;
          error_d   = alu_error;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TimeoutVal) begin
            result_d  = 16'hFFFF;
            error_d   = 1'b0;
            timeout_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluOp_q   <= op_nop;
      tag_q     <= '0;
      timer_q   <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluOp_q   <= aluOp_d;
      tag_q     <= tag_d;
      timer_q   <= timer_d;
      result_q  <= result_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_op      = aluOp_q;
  assign alu_start   = (state_q == ISSUE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_result  = result_q;
  assign rsp_error   = error_q;
  assign rsp_timeout = timeout_q;
  assign rsp_tag     = tag_q;
  assign fifo_count  = count_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] statCmds_q, statErrs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      statCmds_q <= '0;
      statErrs_q <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (statCmds_q != 16'hFFFF) statCmds_q <= statCmds_q + 16'd1;
      if ((error_q | timeout_q) && (statErrs_q != 16'hFFFF)) statErrs_q <= statErrs_q + 16'd1;
    end
  end

  assign stat_cmds = statCmds_q;
  assign stat_errs = statErrs_q;
`endif

endmodule
